// File: rtl/stage_4_mem_pkg.sv
// Shared opcodes, func_3 access codes, FSM encoding and sign-extension helper for the memory stage.
// Pure declarations: no latency, no flow control.
package stage_4_mem_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  function automatic logic [31:0] sign_extend(input logic [15:0] v, input logic is_half);
    return is_half ? {{16{v[15]}}, v} : {{24{v[7]}}, v[7:0]};
  endfunction

endpackage

// File: rtl/stage_4_mem_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational, no latency, no flow control.
module stage_4_mem_load_align
  import stage_4_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func_3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr, 3'b000};

  always_comb begin
    result = rdata;
    case (func_3)
      F3_LB:   result = sign_extend(shifted[15:0], 1'b0);
      F3_LBU:  result = {24'd0, shifted[7:0]};
      F3_LH:   result = sign_extend(shifted[15:0], 1'b1);
      F3_LHU:  result = {16'd0, shifted[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_4_mem.sv
// RISC-V memory stage: req/ack data-memory access, load alignment, registered writeback.
// Non-mem ops 1 cycle; mem ops 1 + bus wait + 1; stall holds upstream while an access is pending.
module stage_4_mem
  import stage_4_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_num,
  output logic        wb_we,
  output logic        misaligned,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [4:0]    rd_q;
  logic          is_store, legal, accept, ack_hit, timeout;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt, load_res;

  // Unknown func_3 codes fall through as illegal and are reported like misalignment.
  always_comb begin
    is_store = (i_opcode == OPC_STORE);
    legal    = 1'b0;
    case (i_func_3)
      F3_LB:   legal = 1'b1;
      F3_LH:   legal = ~i_alu_out[0];
      F3_LW:   legal = (i_alu_out[1:0] == 2'b00);
      F3_LBU:  legal = ~is_store;
      F3_LHU:  legal = ~is_store & ~i_alu_out[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = i_rs_2;
    case (i_func_3)
      F3_SB: begin
        be_nxt    = 4'b0001 << i_alu_out[1:0];
        wdata_nxt = {4{i_rs_2[7:0]}};
      end
      F3_SH: begin
        be_nxt    = 4'b0011 << i_alu_out[1:0];
        wdata_nxt = {2{i_rs_2[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = i_rs_2;
      end
    endcase
  end

  assign accept  = (state == IDLE) & i_valid & i_op_type & legal;
  assign stall   = (state == BUS) | accept;
  assign ack_hit = (state == BUS) & dmem_ack;
  assign timeout = (state == BUS) & ~dmem_ack & (TIMEOUT != 0) & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUS;
      BUS:     if (ack_hit | timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  stage_4_mem_load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (off_q),
    .func_3 (f3_q),
    .result (load_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd_num  <= '0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_valid & ~i_op_type) begin
            wb_valid  <= 1'b1;
            wb_data   <= i_alu_out;
            wb_rd_num <= i_rd_num;
            wb_we     <= (i_rd_num != 5'd0);
          end else if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {i_alu_out[31:2], 2'b00};
            dmem_wdata <= wdata_nxt;
            dmem_be    <= be_nxt;
            off_q      <= i_alu_out[1:0];
            f3_q       <= i_func_3;
            rd_q       <= i_rd_num;
          end else if (i_valid & i_op_type) begin
            misaligned <= 1'b1;
          end
        end
        BUS: begin
          if (ack_hit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            wb_valid  <= 1'b1;
            wb_rd_num <= rd_q;
            if (!dmem_we) begin
              wb_we   <= (rd_q != 5'd0);
              wb_data <= load_res;
            end
          end else if (timeout) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_4_mem.sv
// Directed and random checks of stage_4_mem against an arithmetic reference model.
module tb_stage_4_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_alu_out = '0;
  logic [31:0] i_rs_2 = '0;
  logic [4:0]  i_rd_num = '0;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_func_3 = '0;
  logic        i_op_type = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall, dmem_req, dmem_we, wb_valid, wb_we, misaligned, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd_num;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage_4_mem #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_alu_out(i_alu_out), .i_rs_2(i_rs_2),
    .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_num(wb_rd_num), .wb_we(wb_we),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit store, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz = acc_size(f3);
    if (sz == 0) return 0;
    if (store && f3 > 3'd2) return 0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz = acc_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (acc_size(f3))
      1:       return (rs2 & 32'hFF) * 32'h01010101;
      2:       return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 32'd256;   end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 32'd65536; end
      3'd5: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic run_op(input string tag, input bit mem, input bit store, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input int waits, input logic [31:0] rdata, input bit never_ack);
    bit ok = mem && ref_legal(store, f3, addr);
    i_valid   = 1'b1;
    i_op_type = mem;
    i_opcode  = !mem ? 7'h13 : (store ? 7'h23 : 7'h03);
    i_func_3  = f3;
    i_alu_out = addr;
    i_rs_2    = rs2;
    i_rd_num  = rd;
    #1 chk({tag, "/stall_in"}, stall, ok);
    tick();
    i_valid   = 1'b0;
    i_op_type = 1'b0;
    if (!mem) begin
      chk({tag, "/wb_valid"}, wb_valid, 1);
      chk({tag, "/wb_data"}, wb_data, addr);
      chk({tag, "/wb_rd"}, wb_rd_num, rd);
      chk({tag, "/wb_we"}, wb_we, rd != 0);
      chk({tag, "/no_req"}, dmem_req, 0);
    end else if (!ok) begin
      chk({tag, "/misaligned"}, misaligned, 1);
      chk({tag, "/no_wb"}, wb_valid, 0);
      chk({tag, "/no_req"}, dmem_req, 0);
      tick();
      chk({tag, "/mis_pulse"}, misaligned, 0);
    end else begin
      chk({tag, "/req"}, dmem_req, 1);
      chk({tag, "/we"}, dmem_we, store);
      chk({tag, "/addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "/stall_bus"}, stall, 1);
      if (store) begin
        chk({tag, "/be"}, dmem_be, ref_be(f3, addr));
        chk({tag, "/wdata"}, dmem_wdata, ref_wdata(f3, rs2));
      end
      if (never_ack) begin
        for (int i = 0; i < 3; i++) begin
          tick();
          chk({tag, "/req_hold"}, dmem_req, 1);
        end
        tick();
        chk({tag, "/req_drop"}, dmem_req, 0);
        chk({tag, "/bus_err"}, bus_err, 1);
        chk({tag, "/stall_rel"}, stall, 0);
        chk({tag, "/to_no_wb"}, wb_valid, 0);
        tick();
        chk({tag, "/err_pulse"}, bus_err, 0);
      end else begin
        for (int i = 0; i < waits; i++) begin
          tick();
          chk({tag, "/req_wait"}, dmem_req, 1);
          chk({tag, "/addr_stable"}, dmem_addr, addr & 32'hFFFF_FFFC);
          chk({tag, "/stall_wait"}, stall, 1);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        chk({tag, "/wb_valid"}, wb_valid, 1);
        chk({tag, "/wb_we"}, wb_we, !store && rd != 0);
        chk({tag, "/req_done"}, dmem_req, 0);
        chk({tag, "/stall_done"}, stall, 0);
        if (!store) begin
          chk({tag, "/wb_rd"}, wb_rd_num, rd);
          chk({tag, "/wb_data"}, wb_data, ref_load(rdata, addr, f3));
        end
        tick();
        chk({tag, "/wb_pulse"}, wb_valid, 0);
        chk({tag, "/wb_we_idle"}, wb_we, 0);
      end
    end
  endtask

  initial begin
    #12;
    chk("rst/stall", stall, 0);
    chk("rst/req", dmem_req, 0);
    chk("rst/we", dmem_we, 0);
    chk("rst/be", dmem_be, 0);
    chk("rst/wb_valid", wb_valid, 0);
    chk("rst/wb_data", wb_data, 0);
    chk("rst/misaligned", misaligned, 0);
    chk("rst/bus_err", bus_err, 0);
    rst_n = 1'b1;
    tick();

    run_op("addi",   0, 0, 3'd0, 32'h0000_1234, 0,            5'd5, 0, 0,            0);
    run_op("sw",     1, 1, 3'd2, 32'h0000_0100, 32'hDEADBEEF, 5'd7, 3, 0,            0);
    run_op("lb",     1, 0, 3'd0, 32'h0000_0103, 0,            5'd9, 1, 32'h80FF7F01, 0);
    run_op("lbu",    1, 0, 3'd4, 32'h0000_0103, 0,            5'd9, 0, 32'h80FF7F01, 0);
    run_op("sh",     1, 1, 3'd1, 32'h0000_0102, 32'h0000ABCD, 5'd0, 2, 0,            0);
    run_op("lw_mis", 1, 0, 3'd2, 32'h0000_0102, 0,            5'd3, 0, 0,            0);
    run_op("lh_rd0", 1, 0, 3'd1, 32'h0000_0102, 0,            5'd0, 0, 32'hBEEF1234, 0);
    run_op("tmo",    1, 0, 3'd2, 32'h0000_0200, 0,            5'd4, 0, 0,            1);

    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack/wb_valid", wb_valid, 0);
    chk("idle_ack/req", dmem_req, 0);

    i_valid = 1'b1; i_op_type = 1'b1; i_opcode = 7'h03; i_func_3 = 3'd2;
    i_alu_out = 32'h300; i_rd_num = 5'd6;
    tick();
    i_valid = 1'b0; i_op_type = 1'b0;
    chk("rst_bus/req_on", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_bus/req_off", dmem_req, 0);
    chk("rst_bus/stall", stall, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_bus/after_req", dmem_req, 0);
    chk("rst_bus/after_wb", wb_valid, 0);

    for (int n = 0; n < 60; n++) begin
      int unsigned kind = $urandom_range(0, 2);
      run_op("rnd", kind != 0, kind == 2, 3'($urandom_range(0, 7)),
             32'h400 + $urandom_range(0, 255), $urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), $urandom, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
